uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NUM_REQ byte-stream requesters.
- Picks a requester round-robin and delivers its byte to the transmitter's data load strobe and data bus.
- Sequences the transmitter by watching its tbr (transmit buffer ready) output through load, busy and done phases.
- Inserts a programmable inter-frame gap; flags a transmitter that never goes busy after a load.

---
 rtl/uart_tx_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } arb_state_t;

  // Inter-frame gap counter holds up to 255 idle cycles.
  localparam int GAP_W = 8;
  // Busy timeout counter holds up to 15 cycles.
  localparam int TMO_W = 4;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART transmit arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester; tbr paces the transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_tx_arb_pkg::*;

  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_load;
  logic                 tbr;
  logic [IW-1:0]        grant_id;
  logic                 busy;
  logic                 tx_err;

  // Requesters and transmitter model: drive bytes and tbr, observe the arbiter.
  modport master (
    output req_valid, req_data, req_last, tbr,
    input  req_ready, tx_data, tx_load, grant_id, busy, tx_err
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data, req_last, tbr,
    output req_ready, tx_data, tx_load, grant_id, busy, tx_err
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first masked request at or above rr_ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is taken.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0]  cand;
  logic [IW-1:0] pos;

  // Scan from rr_ptr upward; the first eligible requester wins.
  always_comb begin
    cand  = req & mask;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = IW'((int'(rr_ptr) + i) % N);
      if (!any && cand[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters, round-robin; optional packet lock via UART_TXA_LOCK_EN.
// Latency: acceptance edge to tx_load is 1 cycle; frames spaced by frame time + IFG_CYCLES + 2.
// Backpressure: req_ready only in IDLE with tbr=1; tx_err is sticky if tbr never falls after a load.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IFG_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    rr_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic [NUM_REQ-1:0] pick_mask;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               accept;
  logic               tmo_hit;
  logic [IW-1:0]      rr_nxt;

`ifdef UART_TXA_LOCK_EN
  logic locked;

  // While a packet is in progress only its owner may be picked.
  always_comb pick_mask = locked ? (NUM_REQ'(1) << bus.grant_id) : '1;

  // Lock on a non-last byte, release on the last byte or on a busy timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          locked <= 1'b0;
    else if (tmo_hit) locked <= 1'b0;
    else if (accept)  locked <= ~bus.req_last[pick_idx];
  end
`else
  wire unused_req_last = ^bus.req_last;

  // Byte-level arbitration: every requester is always eligible.
  always_comb pick_mask = '1;
`endif

  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .mask   (pick_mask),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign accept        = (state == IDLE) && bus.tbr && pick_any;
  assign tmo_hit       = (state == WAIT_BUSY) && bus.tbr && (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1));
  assign rr_nxt        = IW'((int'(pick_idx) + 1) % NUM_REQ);
  assign bus.req_ready = (accept && !rst) ? pick_grant : '0;
  assign bus.tx_load   = (state == LOAD);
  assign bus.busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sequence the transmitter through load, busy and done, then the idle gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.tbr)     state_nxt = WAIT_DONE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (bus.tbr) state_nxt = (IFG_CYCLES > 0) ? GAP : IDLE;
      GAP:       if (gap_cnt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Capture the winner's byte, advance the pointer, run gap and timeout counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tx_data  <= '0;
      bus.grant_id <= '0;
      bus.tx_err   <= 1'b0;
      rr_ptr       <= '0;
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      if (accept) begin
        bus.tx_data  <= bus.req_data[8*int'(pick_idx) +: 8];
        bus.grant_id <= pick_idx;
`ifdef UART_TXA_LOCK_EN
        if (bus.req_last[pick_idx]) rr_ptr <= rr_nxt;
`else
        rr_ptr <= rr_nxt;
`endif
      end
      if (state == LOAD) tmo_cnt <= '0;
      else if (state == WAIT_BUSY && bus.tbr && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) bus.tx_err <= 1'b1;
      if (state == WAIT_DONE && bus.tbr && IFG_CYCLES > 0) gap_cnt <= GAP_W'(IFG_CYCLES - 1);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a queue-backed requester model and a tbr transmitter model.
// Latency: expects tx_load one cycle after req_ready, frames spaced by the inter-frame gap.
// Backpressure: tbr model can stall (held low), or never go busy (held high) to provoke the timeout.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .IFG_CYCLES   (3),
    .BUSY_TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0] rq [N][$];   // {last, data} per requester
  logic [9:0] exp_q [$];   // {grant_id, data} in expected load order
  int         tbr_mode = 0; // 0 normal, 1 never busy, 2 held low
  logic       gap_chk  = 1'b0;
  int         gap_seen = 0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        bus.req_valid[k]       = 1'b1;
        bus.req_data[8*k +: 8] = rq[k][0][7:0];
        bus.req_last[k]        = rq[k][0][8];
      end else begin
        bus.req_valid[k]       = 1'b0;
        bus.req_data[8*k +: 8] = 8'h00;
        bus.req_last[k]        = 1'b0;
      end
    end
  endtask

  task automatic add(input int k, input logic [7:0] d, input logic last);
    rq[k].push_back({last, d});
  endtask

  task automatic expect_load(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int k = 0; k < N; k++) if (rq[k].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((pending() || exp_q.size() != 0 || bus.busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain_in_time"}, int'(t < 3000), 1);
    tick(2);
  endtask

  task automatic wait_load(input string nm);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.tx_load && t < 100);
    chk({nm, "_load_seen"}, int'(bus.tx_load), 1);
  endtask

  // Requester model: consume on valid&ready at the edge, then present the next byte.
  initial begin
    logic [N-1:0] acc;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      acc = bus.req_valid & bus.req_ready;
      #1;
      for (int k = 0; k < N; k++) if (acc[k]) void'(rq[k].pop_front());
      drive_reqs();
    end
  end

  // Transmitter model: tbr falls one cycle after tx_load and rises 10 cycles later.
  initial begin
    logic ld;
    int   cnt = 0;
    bus.tbr = 1'b1;
    forever begin
      @(posedge clk);
      ld = bus.tx_load;
      #1;
      if (rst) begin
        cnt     = 0;
        bus.tbr = (tbr_mode != 2);
      end else if (tbr_mode == 2) begin
        bus.tbr = 1'b0;
      end else if (tbr_mode == 1) begin
        bus.tbr = 1'b1;
      end else if (ld) begin
        bus.tbr = 1'b0;
        cnt     = 10;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.tbr = 1'b1;
      end else begin
        bus.tbr = 1'b1;
      end
    end
  end

  // Monitor: pop the scoreboard on every load; check ready legality, load latency and gap.
  logic [9:0] mon_e;
  logic       tbr_q     = 1'b1;
  int         ready_cyc = -10;
  int         rise_cyc  = 0;
  logic       rise_pend = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.req_ready != '0) begin
        chk("ready_onehot", $countones(bus.req_ready), 1);
        chk("ready_only_idle", int'(bus.busy), 0);
        ready_cyc = cyc;
        if (gap_chk && rise_pend) begin
          chk("ifg_spacing_ok", int'((cyc - rise_cyc) >= 4), 1);
          gap_seen++;
          rise_pend = 1'b0;
        end
      end
      if (gap_chk && bus.tbr && !tbr_q) begin
        rise_cyc  = cyc;
        rise_pend = 1'b1;
      end
      if (bus.tx_load) begin
        chk("load_latency", cyc - ready_cyc, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_id", int'(bus.grant_id), int'(mon_e[9:8]));
          chk("tx_data", int'(bus.tx_data), int'(mon_e[7:0]));
        end
      end
    end
    tbr_q = bus.tbr;
  end

  // Directed sequence.
  initial begin
    logic seen;
    tick(2);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tx_load", int'(bus.tx_load), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_grant_id", int'(bus.grant_id), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_tx_err", int'(bus.tx_err), 0);
    rst = 1'b0;
    tick(2);

    // Single requester.
    @(posedge clk); #2;
    add(1, 8'hA5, 1'b1); expect_load(2'd1, 8'hA5); drive_reqs();
    @(negedge clk);
    chk("t1_req_ready", int'(bus.req_ready), 4'b0010);
    wait_drain("t1");

    // Fresh pointer, all four valid, gap of 3.
    @(negedge clk) rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    gap_chk = 1'b1;
    @(posedge clk); #2;
    add(0, 8'h10, 1'b1); add(1, 8'h11, 1'b1); add(2, 8'h12, 1'b1); add(3, 8'h13, 1'b1);
    add(0, 8'h14, 1'b1);
    expect_load(2'd0, 8'h10); expect_load(2'd1, 8'h11); expect_load(2'd2, 8'h12);
    expect_load(2'd3, 8'h13); expect_load(2'd0, 8'h14);
    drive_reqs();
    wait_drain("t2");
    gap_chk = 1'b0;
    chk("t2_gaps_checked", gap_seen, 4);

    // Busy timeout: tbr never falls.
    tbr_mode = 1;
    @(posedge clk); #2;
    add(3, 8'h3C, 1'b1); expect_load(2'd3, 8'h3C); drive_reqs();
    wait_load("t3");
    tick(4);
    chk("t3_err_before_timeout", int'(bus.tx_err), 0);
    tick(1);
    chk("t3_err_at_timeout", int'(bus.tx_err), 1);
    chk("t3_idle_after_timeout", int'(bus.busy), 0);
    tbr_mode = 0;
    tick(2);

    // tbr low in IDLE blocks all acceptance.
    tbr_mode = 2;
    tick(2);
    @(posedge clk); #2;
    add(0, 8'h40, 1'b1); add(1, 8'h41, 1'b1); add(2, 8'h42, 1'b1); add(3, 8'h43, 1'b1);
    drive_reqs();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.req_ready != '0) seen = 1'b1;
    end
    chk("t4_no_ready_while_tbr0", int'(seen), 0);
    chk("t4_err_sticky", int'(bus.tx_err), 1);
    expect_load(2'd0, 8'h40); expect_load(2'd1, 8'h41);
    expect_load(2'd2, 8'h42); expect_load(2'd3, 8'h43);
    tbr_mode = 0;
    wait_drain("t4");
    chk("t4_err_still_set", int'(bus.tx_err), 1);

    // Async reset in WAIT_DONE.
    @(posedge clk); #2;
    add(2, 8'h5A, 1'b1); expect_load(2'd2, 8'h5A); drive_reqs();
    wait_load("t5");
    tick(3);
    chk("t5_busy_before_rst", int'(bus.busy), 1);
    chk("t5_grant_before_rst", int'(bus.grant_id), 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_tx_load", int'(bus.tx_load), 0);
    chk("t5_rst_req_ready", int'(bus.req_ready), 0);
    chk("t5_rst_grant_id", int'(bus.grant_id), 0);
    chk("t5_rst_tx_err", int'(bus.tx_err), 0);
    @(negedge clk) rst = 1'b0;
    tick(1);
    @(posedge clk); #2;
    add(1, 8'h61, 1'b1); add(3, 8'h63, 1'b1);
    expect_load(2'd1, 8'h61); expect_load(2'd3, 8'h63);
    drive_reqs();
    wait_drain("t5");

    // Multi-byte packet from requester 0 competing with requester 2.
    @(posedge clk); #2;
    add(0, 8'h70, 1'b0); add(0, 8'h71, 1'b0); add(0, 8'h72, 1'b1);
    add(2, 8'h80, 1'b1); add(2, 8'h81, 1'b1);
`ifdef UART_TXA_LOCK_EN
    expect_load(2'd0, 8'h70); expect_load(2'd0, 8'h71); expect_load(2'd0, 8'h72);
    expect_load(2'd2, 8'h80); expect_load(2'd2, 8'h81);
`else
    expect_load(2'd0, 8'h70); expect_load(2'd2, 8'h80); expect_load(2'd0, 8'h71);
    expect_load(2'd2, 8'h81); expect_load(2'd0, 8'h72);
`endif
    drive_reqs();
    wait_drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
    $fatal(1);
  end

endmodule
